dmem_access_ctrl: RTL and testbench

MEM-stage sequencer for the 5-stage pipeline's data memory. It takes the memory-control bits and operands held in the EX/MEM pipeline register and runs a req/ack handshake to a variable-latency data memory. While an access is in flight it freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) and returns registered load data to the MEM/WB path. It also flags misaligned or illegal accesses and memory timeouts.

---
 rtl/dmem_ctrl_pkg.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer: state encoding,
// alignment mask and request classification helpers.
package dmem_ctrl_pkg;

   // Sequencer states; 2'b11 is unused and recovers to idle.
   typedef logic [1:0] state_t;

   localparam state_t StIdle   = 2'b00;
   localparam state_t StAccess = 2'b01;
   localparam state_t StDone   = 2'b10;

   // Low address bits that must be zero for a word access.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [31:0] a);
      return (a[1:0] & ALIGN_MASK) == 2'b00;
   endfunction

   // Exactly one of read/write, word aligned: start a memory access.
   function automatic logic is_go(input logic rd, input logic wr, input logic [31:0] a);
      return (rd ^ wr) && is_aligned(a);
   endfunction

   // Conflicting control bits, or a request to a misaligned address.
   function automatic logic is_bad(input logic rd, input logic wr, input logic [31:0] a);
      return (rd && wr) || ((rd || wr) && !is_aligned(a));
   endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer. Runs a req/ack handshake to a
// variable-latency memory, freezes the upstream pipeline while the access is in
// flight, registers load data for MEM/WB and flags illegal accesses and timeouts.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        access_err,
   output logic        timeout_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;
   logic [31:0]      rdata_q;
   logic             timeout_err_q;

   logic go;
   logic bad;
   logic capture;
   logic load_rdata;
   logic set_timeout;

   assign go  = is_go(mem_read, mem_write, addr);
   assign bad = is_bad(mem_read, mem_write, addr);

   // Next-state, wait counter and register-update strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      capture     = 1'b0;
      load_rdata  = 1'b0;
      set_timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Illegal requests fall through as bubbles; ack here is stray.
            if (go) begin
               state_d = StAccess;
               cnt_d   = '0;
               capture = 1'b1;
            end
         end
         StAccess: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (mem_ack) begin
               state_d    = StDone;
               load_rdata = !mem_we_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = StDone;
               set_timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            // EX/MEM still holds the finished instruction; do not look at it.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer state and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request fields are latched once at the start and held through the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else if (capture) begin
         mem_we_q    <= mem_write;
         mem_addr_q  <= addr;
         mem_wdata_q <= wdata;
      end
   end

   // Load result register feeding MEM/WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (load_rdata) begin
         rdata_q <= mem_rdata;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_err_q <= 1'b0;
      end else if (set_timeout) begin
         timeout_err_q <= 1'b1;
      end
   end

   // Outputs: request decoded from registered state, stall and error from inputs.
   always_comb begin
      mem_req     = (state_q == StAccess);
      mem_we      = mem_we_q;
      mem_addr    = mem_addr_q;
      mem_wdata   = mem_wdata_q;
      rdata       = rdata_q;
      timeout_err = timeout_err_q;
      stall       = !rst && (((state_q == StIdle) && go) || (state_q == StAccess));
      access_err  = !rst && (state_q == StIdle) && bad;
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: each access pushes its expected
// memory request and completion state; a negedge monitor checks them.
module tb_dmem_access_ctrl;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] rdata;
   logic        access_err;
   logic        timeout_err;

   dmem_access_ctrl #(
      .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .wdata      (wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .stall      (stall),
      .rdata      (rdata),
      .access_err (access_err),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        we;
      logic        to;
      int          stalls;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_to = 1'b0;
   logic        req_prev = 1'b0;
   int          stall_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Monitor: checks request fields during ACCESS and completion in DONE.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            req_prev  = 1'b0;
            stall_cnt = 0;
         end else begin
            if (stall) stall_cnt++;
            if (mem_req) begin
               if (sb.size() == 0) begin
                  check_val("unexpected_req", {31'd0, mem_req}, 32'd0);
               end else begin
                  check_val("mem_addr", mem_addr, sb[0].addr);
                  check_val("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                  check_val("mem_wdata", mem_wdata, sb[0].wdata);
               end
            end
            if (req_prev && !mem_req) begin
               if (sb.size() == 0) begin
                  check_val("done_no_entry", 32'd1, 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check_val("done_rdata", rdata, mon_e.rdata);
                  check_val("done_stall", {31'd0, stall}, 32'd0);
                  check_val("stall_cycles", stall_cnt, mon_e.stalls);
                  check_val("timeout_err", {31'd0, timeout_err}, {31'd0, mon_e.to});
               end
               stall_cnt = 0;
            end
            req_prev = mem_req;
         end
      end
   end

   // Starts at posedge+1 of an IDLE cycle; ack_at < 0 means the memory never acks.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at,
                            input logic [31:0] rdat, input bit dup_ack);
      exp_t e;
      int   n_acc;
      n_acc = (ack_at < 0) ? int'(TO) : ack_at + 1;
      if (rd && ack_at >= 0) exp_rdata = rdat;
      if (ack_at < 0) exp_to = 1'b1;
      e.addr   = a;
      e.wdata  = wd;
      e.we     = wr;
      e.rdata  = exp_rdata;
      e.to     = exp_to;
      e.stalls = n_acc + 1;
      sb.push_back(e);
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = wd;
      @(posedge clk) #1;
      for (int k = 0; k < n_acc; k++) begin
         if (k == ack_at) begin
            mem_ack   = 1'b1;
            mem_rdata = rdat;
         end
         @(posedge clk) #1;
         mem_ack   = 1'b0;
         mem_rdata = 32'hXXXX_0000;
      end
      // DONE cycle: the finished instruction is still on the inputs.
      if (dup_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end
      @(posedge clk) #1;
      mem_ack   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      check_val("rdata_hold", rdata, exp_rdata);
   endtask

   task automatic bad_access(input logic rd, input logic wr, input logic [31:0] a);
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      @(negedge clk);
      check_val("bad_err", {31'd0, access_err}, 32'd1);
      check_val("bad_stall", {31'd0, stall}, 32'd0);
      check_val("bad_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk) #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      check_val("bad_err_pulse", {31'd0, access_err}, 32'd0);
      check_val("bad_rdata", rdata, exp_rdata);
      @(posedge clk) #1;
   endtask

   task automatic idle_ack();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_2222;
      @(posedge clk) #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check_val("idle_ack_rdata", rdata, exp_rdata);
      check_val("idle_ack_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk) #1;
   endtask

   // Load that is reset during its second wait cycle.
   task automatic reset_mid();
      exp_t e;
      e.addr   = 32'h0000_0080;
      e.wdata  = 32'h0;
      e.we     = 1'b0;
      e.rdata  = exp_rdata;
      e.to     = exp_to;
      e.stalls = 0;
      sb.push_back(e);
      mem_read  = 1'b1;
      mem_write = 1'b0;
      addr      = 32'h0000_0080;
      wdata     = 32'h0;
      @(posedge clk) #1;
      @(posedge clk) #3;
      rst = 1'b1;
      sb.delete();
      exp_rdata = '0;
      exp_to    = 1'b0;
      #1;
      check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_rdata", rdata, 32'd0);
      check_val("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      mem_read = 1'b0;
      @(posedge clk) #2;
      rst = 1'b0;
      @(posedge clk) #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = '0;
      wdata     = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #2;
      check_val("init_mem_req", {31'd0, mem_req}, 32'd0);
      check_val("init_mem_we", {31'd0, mem_we}, 32'd0);
      check_val("init_mem_addr", mem_addr, 32'd0);
      check_val("init_mem_wdata", mem_wdata, 32'd0);
      check_val("init_rdata", rdata, 32'd0);
      check_val("init_access_err", {31'd0, access_err}, 32'd0);
      check_val("init_timeout_err", {31'd0, timeout_err}, 32'd0);
      mem_read = 1'b1;
      #1;
      check_val("init_stall_in_rst", {31'd0, stall}, 32'd0);
      mem_read = 1'b0;
      @(posedge clk) #2;
      rst = 1'b0;
      @(posedge clk) #1;

      do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
      do_access(1'b0, 1'b1, 32'h0000_002C, 32'h1234_5678, 2, 32'h0, 1'b0);
      bad_access(1'b1, 1'b0, 32'h0000_0102);
      bad_access(1'b1, 1'b1, 32'h0000_0104);
      idle_ack();
      do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, -1, 32'h0, 1'b0);
      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hA5A5_0010, 1'b1);
      do_access(1'b0, 1'b1, 32'h0000_0014, 32'h5555_AAAA, 0, 32'h0, 1'b0);
      reset_mid();
      do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_BEEF, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_val("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
